// File: rtl/mini_cpu_pkg.sv
// Shared constants for the mini CPU control slice: opcodes, ALU encodings,
// sequencer state encoding and field widths.
package mini_cpu_pkg;

   localparam int SEL_W      = 3;
   localparam int REG_ADDR_W = 2;
   localparam int ALU_OP_W   = 2;
   localparam int STATE_W    = 3;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_ADD   = 3'd2;
   localparam logic [2:0] OP_SUB   = 3'd3;
   localparam logic [2:0] OP_AND   = 3'd4;
   localparam logic [2:0] OP_STORE = 3'd5;
   localparam logic [2:0] OP_JZ    = 3'd6;
   localparam logic [2:0] OP_HALT  = 3'd7;

   localparam logic [ALU_OP_W-1:0] ALU_PASS = 2'd0;
   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 2'd1;
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = 2'd2;
   localparam logic [ALU_OP_W-1:0] ALU_AND  = 2'd3;

   localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] ST_FETCH   = 3'd1;
   localparam logic [STATE_W-1:0] ST_DECODE  = 3'd2;
   localparam logic [STATE_W-1:0] ST_EXECUTE = 3'd3;
   localparam logic [STATE_W-1:0] ST_HALT    = 3'd4;

   // Mux input 7 is reserved downstream; an instruction naming it is fatal.
   localparam logic [SEL_W-1:0] SEL_ILLEGAL = 3'd7;

   typedef enum logic [2:0] {
      CLS_NOP,
      CLS_ACC,
      CLS_STORE,
      CLS_JZ,
      CLS_HALT
   } op_class_e;

endpackage

// File: rtl/mini_cpu_decode.sv
// Combinational instruction decoder: splits the IR into opcode class,
// operand select, ALU operation, register address and jump target.
module mini_cpu_decode
   import mini_cpu_pkg::*;
#(
   parameter int PC_W = 5
) (
   input  logic [7:0]            ir,
   output op_class_e             op_class,
   output logic [SEL_W-1:0]      sel,
   output logic [ALU_OP_W-1:0]   alu_op,
   output logic [REG_ADDR_W-1:0] reg_addr,
   output logic [PC_W-1:0]       jump_target,
   output logic                  illegal_sel
);

   logic [2:0] opcode;

   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      opcode      = ir[7:5];
      sel         = ir[2:0];
      reg_addr    = ir[4:3];
      jump_target = PC_W'(ir[4:0]);
      alu_op      = ALU_PASS;
      op_class    = CLS_NOP;
      case (opcode)
         OP_LOAD: begin
            op_class = CLS_ACC;
            alu_op   = ALU_PASS;
         end
         OP_ADD: begin
            op_class = CLS_ACC;
            alu_op   = ALU_ADD;
         end
         OP_SUB: begin
            op_class = CLS_ACC;
            alu_op   = ALU_SUB;
         end
         OP_AND: begin
            op_class = CLS_ACC;
            alu_op   = ALU_AND;
         end
         OP_STORE: op_class = CLS_STORE;
         OP_JZ:    op_class = CLS_JZ;
         OP_HALT:  op_class = CLS_HALT;
         default:  op_class = CLS_NOP;
      endcase
      illegal_sel = (op_class == CLS_ACC) && (ir[2:0] == SEL_ILLEGAL);
   end

endmodule

// File: rtl/mini_cpu_control.sv
// Fetch/decode/execute sequencer for the 8-bit mini CPU. All outputs are
// registered. Define MINI_CPU_RETIRE_COUNT_EN to add the RetireCount output.
module mini_cpu_control
   import mini_cpu_pkg::*;
#(
   parameter int              PC_W     = 5,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [7:0]            Instr,
   input  logic                  InstrValid,
   input  logic                  AccZero,
   output logic [PC_W-1:0]       PC,
   output logic                  InstrReq,
   output logic [SEL_W-1:0]      Sel,
   output logic [ALU_OP_W-1:0]   AluOp,
   output logic                  AccLoad,
   output logic                  RegWrite,
   output logic [REG_ADDR_W-1:0] RegAddr,
   output logic                  Halted,
   output logic                  IllegalSel
`ifdef MINI_CPU_RETIRE_COUNT_EN
   ,
   output logic [15:0]           RetireCount
`endif
);

   logic [STATE_W-1:0]    state_q,       state_d;
   logic [PC_W-1:0]       pc_q,          pc_d;
   logic [7:0]            ir_q,          ir_d;
   logic [SEL_W-1:0]      sel_q,         sel_d;
   logic [ALU_OP_W-1:0]   alu_op_q,      alu_op_d;
   logic [REG_ADDR_W-1:0] reg_addr_q,    reg_addr_d;
   logic                  instr_req_q,   instr_req_d;
   logic                  acc_load_q,    acc_load_d;
   logic                  reg_write_q,   reg_write_d;
   logic                  halted_q,      halted_d;
   logic                  illegal_sel_q, illegal_sel_d;

   op_class_e             dec_class;
   logic [SEL_W-1:0]      dec_sel;
   logic [ALU_OP_W-1:0]   dec_alu_op;
   logic [REG_ADDR_W-1:0] dec_reg_addr;
   logic [PC_W-1:0]       dec_jump_target;
   logic                  dec_illegal_sel;

   mini_cpu_decode #(
      .PC_W (PC_W)
   ) u_decode (
      .ir          (ir_q),
      .op_class    (dec_class),
      .sel         (dec_sel),
      .alu_op      (dec_alu_op),
      .reg_addr    (dec_reg_addr),
      .jump_target (dec_jump_target),
      .illegal_sel (dec_illegal_sel)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ir_d          = ir_q;
      sel_d         = sel_q;
      alu_op_d      = alu_op_q;
      reg_addr_d    = reg_addr_q;
      illegal_sel_d = illegal_sel_q;

      case (state_q)
         ST_IDLE: begin
            if (Start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (InstrValid) begin
               ir_d    = Instr;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (dec_class == CLS_HALT) begin
               state_d = ST_HALT;
            end else if (dec_illegal_sel) begin
               // Sel keeps its old value so input 7 never reaches the mux.
               illegal_sel_d = 1'b1;
               state_d       = ST_HALT;
            end else begin
               state_d = ST_EXECUTE;
               if (dec_class == CLS_ACC) begin
                  sel_d    = dec_sel;
                  alu_op_d = dec_alu_op;
               end
               if (dec_class == CLS_STORE) reg_addr_d = dec_reg_addr;
            end
         end
         ST_EXECUTE: begin
            if (dec_class == CLS_JZ && AccZero) pc_d = dec_jump_target;
            else                               pc_d = pc_q + PC_W'(1);
            state_d = ST_FETCH;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase

      // Strobes are registered from the next state so they line up exactly
      // with the cycle the FSM spends in FETCH / EXECUTE / HALT.
      instr_req_d = (state_d == ST_FETCH);
      acc_load_d  = (state_d == ST_EXECUTE) && (dec_class == CLS_ACC);
      reg_write_d = (state_d == ST_EXECUTE) && (dec_class == CLS_STORE);
      halted_d    = halted_q || (state_d == ST_HALT);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge value of its neighbours.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         ir_q          <= '0;
         sel_q         <= '0;
         alu_op_q      <= ALU_PASS;
         reg_addr_q    <= '0;
         instr_req_q   <= 1'b0;
         acc_load_q    <= 1'b0;
         reg_write_q   <= 1'b0;
         halted_q      <= 1'b0;
         illegal_sel_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ir_q          <= ir_d;
         sel_q         <= sel_d;
         alu_op_q      <= alu_op_d;
         reg_addr_q    <= reg_addr_d;
         instr_req_q   <= instr_req_d;
         acc_load_q    <= acc_load_d;
         reg_write_q   <= reg_write_d;
         halted_q      <= halted_d;
         illegal_sel_q <= illegal_sel_d;
      end
   end

   assign PC         = pc_q;
   assign InstrReq   = instr_req_q;
   assign Sel        = sel_q;
   assign AluOp      = alu_op_q;
   assign AccLoad    = acc_load_q;
   assign RegWrite   = reg_write_q;
   assign RegAddr    = reg_addr_q;
   assign Halted     = halted_q;
   assign IllegalSel = illegal_sel_q;

`ifdef MINI_CPU_RETIRE_COUNT_EN
   logic [15:0] retire_count_q, retire_count_d;

   always_comb begin
      retire_count_d = retire_count_q;
      if (state_q == ST_EXECUTE && retire_count_q != 16'hFFFF)
         retire_count_d = retire_count_q + 16'd1;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) retire_count_q <= '0;
      else       retire_count_q <= retire_count_d;
   end

   assign RetireCount = retire_count_q;
`endif

endmodule

// File: tb/tb_mini_cpu_control.sv
// Directed self-checking bench for mini_cpu_control; also covers RetireCount
// when MINI_CPU_RETIRE_COUNT_EN is defined.
module tb_mini_cpu_control;

   logic       Clk;
   logic       Reset;
   logic       Start;
   logic [7:0] Instr;
   logic       InstrValid;
   logic       AccZero;
   logic [4:0] PC;
   logic       InstrReq;
   logic [2:0] Sel;
   logic [1:0] AluOp;
   logic       AccLoad;
   logic       RegWrite;
   logic [1:0] RegAddr;
   logic       Halted;
   logic       IllegalSel;
`ifdef MINI_CPU_RETIRE_COUNT_EN
   logic [15:0] RetireCount;
`endif

   int n_tests;
   int n_fail;

   mini_cpu_control #(
      .PC_W     (5),
      .RESET_PC (5'd0)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Start       (Start),
      .Instr       (Instr),
      .InstrValid  (InstrValid),
      .AccZero     (AccZero),
      .PC          (PC),
      .InstrReq    (InstrReq),
      .Sel         (Sel),
      .AluOp       (AluOp),
      .AccLoad     (AccLoad),
      .RegWrite    (RegWrite),
      .RegAddr     (RegAddr),
      .Halted      (Halted),
      .IllegalSel  (IllegalSel)
`ifdef MINI_CPU_RETIRE_COUNT_EN
      ,
      .RetireCount (RetireCount)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
   endtask

   // From a FETCH cycle, present one instruction and land in the next state
   // (EXECUTE, or HALT for halting instructions).
   task automatic fetch_decode(input logic [7:0] ins);
      Instr      = ins;
      InstrValid = 1'b1;
      tick();
      InstrValid = 1'b0;
      tick();
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      Reset      = 1'b1;
      Start      = 1'b0;
      Instr      = 8'h00;
      InstrValid = 1'b0;
      AccZero    = 1'b0;
      #2;

      // Reset values while Reset is held.
      check("rst_pc",        32'(PC),         0);
      check("rst_sel",       32'(Sel),        0);
      check("rst_aluop",     32'(AluOp),      0);
      check("rst_regaddr",   32'(RegAddr),    0);
      check("rst_instrreq",  32'(InstrReq),   0);
      check("rst_accload",   32'(AccLoad),    0);
      check("rst_regwrite",  32'(RegWrite),   0);
      check("rst_halted",    32'(Halted),     0);
      check("rst_illegal",   32'(IllegalSel), 0);
      tick();
      Reset = 1'b0;
      tick();
      check("idle_no_req", 32'(InstrReq), 0);

      // LOAD src 2 with InstrValid always high.
      Start      = 1'b1;
      Instr      = 8'h22;
      InstrValid = 1'b1;
      tick();
      Start = 1'b0;
      check("load_c1_req",     32'(InstrReq), 1);
      check("load_c1_accload", 32'(AccLoad),  0);
      tick();
      check("load_c2_req",     32'(InstrReq), 0);
      check("load_c2_accload", 32'(AccLoad),  0);
      tick();
      InstrValid = 1'b0;
      check("load_c3_sel",     32'(Sel),     2);
      check("load_c3_aluop",   32'(AluOp),   0);
      check("load_c3_accload", 32'(AccLoad), 1);
      check("load_c3_pc",      32'(PC),      0);
      tick();
      check("load_c4_accload", 32'(AccLoad),  0);
      check("load_c4_pc",      32'(PC),       1);
      check("load_c4_req",     32'(InstrReq), 1);

      // Four stall cycles in FETCH, then a NOP.
      for (int i = 0; i < 4; i++) begin
         check("stall_req",      32'(InstrReq), 1);
         check("stall_strobes",  32'({AccLoad, RegWrite}), 0);
         check("stall_pc",       32'(PC), 1);
         tick();
      end
      check("stall_req_5th", 32'(InstrReq), 1);
      fetch_decode(8'h00);
      check("nop_sel_kept",  32'(Sel), 2);
      check("nop_strobes",   32'({AccLoad, RegWrite}), 0);
      check("nop_req_low",   32'(InstrReq), 0);
      tick();
      check("nop_pc", 32'(PC), 2);

      // JZ taken, not taken, wrap at 31, jump to self.
      AccZero = 1'b1;
      fetch_decode(8'hD0);
      check("jz_strobes", 32'({AccLoad, RegWrite}), 0);
      tick();
      check("jz_taken_pc", 32'(PC), 16);
      AccZero = 1'b0;
      fetch_decode(8'hD0);
      tick();
      check("jz_not_taken_pc", 32'(PC), 17);
      AccZero = 1'b1;
      fetch_decode(8'hDF);
      tick();
      check("jz_to_31_pc", 32'(PC), 31);
      fetch_decode(8'h00);
      tick();
      check("pc_wrap", 32'(PC), 0);
      fetch_decode(8'hC0);
      tick();
      check("jz_self_pc", 32'(PC), 0);
      AccZero = 1'b0;

      // ALU ops: select and operation registered for EXECUTE.
      fetch_decode(8'h43);
      check("add_sel",     32'(Sel),     3);
      check("add_aluop",   32'(AluOp),   1);
      check("add_accload", 32'(AccLoad), 1);
      tick();
      fetch_decode(8'h65);
      check("sub_sel",   32'(Sel),   5);
      check("sub_aluop", 32'(AluOp), 2);
      tick();
      fetch_decode(8'h81);
      check("and_sel",     32'(Sel),     1);
      check("and_aluop",   32'(AluOp),   3);
      check("and_accload", 32'(AccLoad), 1);
      tick();
      check("alu_pc", 32'(PC), 3);

      // STORE to register 3.
      fetch_decode(8'hB8);
      check("store_regaddr",  32'(RegAddr),  3);
      check("store_regwrite", 32'(RegWrite), 1);
      check("store_accload",  32'(AccLoad),  0);
      check("store_sel_kept", 32'(Sel),      1);
      tick();
      check("store_regwrite_off", 32'(RegWrite), 0);
      check("store_pc",           32'(PC),       4);

      // ADD with mux input 7 -> sticky illegal halt.
      fetch_decode(8'h47);
      check("ill_illegal",   32'(IllegalSel), 1);
      check("ill_halted",    32'(Halted),     1);
      check("ill_accload",   32'(AccLoad),    0);
      check("ill_sel_kept",  32'(Sel),        1);
      check("ill_aluop_kept", 32'(AluOp),     3);
      Start      = 1'b1;
      InstrValid = 1'b1;
      tick();
      tick();
      tick();
      Start      = 1'b0;
      InstrValid = 1'b0;
      check("ill_sticky_halted", 32'(Halted),   1);
      check("ill_no_req",        32'(InstrReq), 0);
      check("ill_pc",            32'(PC),       4);

      // HALT opcode.
      do_reset();
      check("post_rst_illegal", 32'(IllegalSel), 0);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      fetch_decode(8'hE0);
      check("halt_halted",  32'(Halted),     1);
      check("halt_illegal", 32'(IllegalSel), 0);
      Start      = 1'b1;
      Instr      = 8'h22;
      InstrValid = 1'b1;
      tick();
      tick();
      Start      = 1'b0;
      InstrValid = 1'b0;
      check("halt_sticky",  32'(Halted),   1);
      check("halt_no_req",  32'(InstrReq), 0);
      check("halt_no_load", 32'(AccLoad),  0);
      check("halt_pc",      32'(PC),       0);

      // Reset in the middle of an ADD's EXECUTE cycle.
      do_reset();
      Start = 1'b1;
      tick();
      Start = 1'b0;
      fetch_decode(8'h42);
      check("abort_accload_pre", 32'(AccLoad), 1);
      #2;
      Reset = 1'b1;
      #1;
      check("abort_accload", 32'(AccLoad), 0);
      check("abort_sel",     32'(Sel),     0);
      check("abort_aluop",   32'(AluOp),   0);
      check("abort_halted",  32'(Halted),  0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      tick();
      check("abort_idle_no_req", 32'(InstrReq), 0);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      check("abort_restart_req", 32'(InstrReq), 1);
      check("abort_restart_pc",  32'(PC),       0);

`ifdef MINI_CPU_RETIRE_COUNT_EN
      do_reset();
      check("retire_rst", 32'(RetireCount), 0);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         fetch_decode(8'h00);
         tick();
      end
      check("retire_three", 32'(RetireCount), 3);
      do_reset();
      check("retire_cleared", 32'(RetireCount), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
